// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared types and helpers for the adder arbiter
package adder_arbiter_pkg;

    // Output stage occupancy: EMPTY holds no response, FULL holds one.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Width of a requester index; never below one bit so the id port exists.
    function automatic int calc_id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - plain wrap-around adder shared by the arbiter
module adder #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] sum_o
);

    // Carry-out is intentionally dropped: results are modulo 2^DATA_WIDTH.
    assign sum_o = a_i + b_i;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search from a pointer
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = calc_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [IDX_WIDTH-1:0] gnt_idx_o,
    output logic                 any_gnt_o
);

    // Walk upward from the pointer, wrapping, and take the first request seen.
    always_comb begin
        int idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_gnt_o && req_i[idx]) begin
                any_gnt_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IDX_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one adder with a registered response stage
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = calc_id_width(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_sum_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    input  logic                          rsp_ready_i
);

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    logic [NUM_REQ-1:0]    gnt;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic                  any_gnt;
    logic                  can_accept;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op1_sel;
    logic [DATA_WIDTH-1:0] op2_sel;
    logic [DATA_WIDTH-1:0] add_sum;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    // One-hot AND-OR mux of the granted requester's operands into the adder.
    always_comb begin
        op1_sel = '0;
        op2_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                op1_sel = op1_sel | req_op1_i[k*DATA_WIDTH +: DATA_WIDTH];
                op2_sel = op2_sel | req_op2_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .a_i   (op1_sel),
        .b_i   (op2_sel),
        .sum_o (add_sum)
    );

    // The stage can take a new request when empty or draining this cycle.
    assign can_accept  = (state_q == EMPTY) || rsp_ready_i;
    assign accept      = any_gnt && can_accept && !arst_i;
    assign req_ready_o = (arst_i || !can_accept) ? '0 : gnt;

    // Next-state, pointer and output-register load decisions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        id_d    = id_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (rsp_ready_i && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            sum_d = add_sum;
            id_d  = gnt_idx;
            ptr_d = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // State, pointer and response registers; reset drops any pending response.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sum_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
        end
    end

    assign rsp_valid_o = (state_q == FULL);
    assign rsp_sum_o   = sum_q;
    assign rsp_id_o    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;

    localparam int DW = 64;
    localparam int NR = 4;
    localparam int IW = 2;

    logic               clk_i = 1'b0;
    logic               arst_i;
    logic [NR-1:0]      req_valid_i;
    logic [NR*DW-1:0]   req_op1_i;
    logic [NR*DW-1:0]   req_op2_i;
    logic [NR-1:0]      req_ready_o;
    logic               rsp_valid_o;
    logic [DW-1:0]      rsp_sum_o;
    logic [IW-1:0]      rsp_id_o;
    logic               rsp_ready_i;

    int n_checks = 0;
    int n_pass   = 0;

    adder_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_WIDTH   (IW)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .req_valid_i (req_valid_i),
        .req_op1_i   (req_op1_i),
        .req_op2_i   (req_op2_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_sum_o   (rsp_sum_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_ready_i (rsp_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input int k, input logic [63:0] a, input logic [63:0] b);
        req_op1_i[k*DW +: DW] = a;
        req_op2_i[k*DW +: DW] = b;
    endtask

    task automatic check_rsp(input string tag, input logic [63:0] sum, input logic [63:0] id);
        check({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
        check({tag, "_sum"}, rsp_sum_o, sum);
        check({tag, "_id"}, 64'(rsp_id_o), id);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        arst_i = 1'b1;
        #2;
        @(negedge clk_i);
        arst_i = 1'b0;
        #1;
    endtask

    // Per-requester sums used in the rotation tests: 30, 11, 3, 42.
    int exp_ids [7] = '{0, 1, 2, 3, 0, 1, 2};
    logic [63:0] exp_sums [4] = '{64'd30, 64'd11, 64'd3, 64'd42};

    initial begin
        arst_i      = 1'b1;
        req_valid_i = 4'b1111;
        req_op1_i   = '0;
        req_op2_i   = '0;
        rsp_ready_i = 1'b1;
        #2;
        check("rst_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_sum", rsp_sum_o, 64'd0);
        check("rst_id", 64'(rsp_id_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd0);

        // Test 1: single request 5+7 from requester 0.
        req_valid_i = 4'b0000;
        do_reset();
        set_op(0, 64'd5, 64'd7);
        req_valid_i = 4'b0001;
        #1;
        check("t1_ready", 64'(req_ready_o), 64'b0001);
        step();
        check_rsp("t1", 64'd12, 64'd0);
        req_valid_i = 4'b0000;
        step();
        check("t1_drain", 64'(rsp_valid_o), 64'd0);

        // Test 2: all valid, rotation 0,1,2,3,0,1 then 2 with no bubbles.
        do_reset();
        set_op(0, 64'd10, 64'd20);
        set_op(1, 64'd5,  64'd6);
        set_op(2, 64'd1,  64'd2);
        set_op(3, 64'd40, 64'd2);
        req_valid_i = 4'b1111;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("t2_ready%0d", i), 64'(req_ready_o), 64'(1 << exp_ids[i]));
            step();
            check_rsp($sformatf("t2_rsp%0d", i), exp_sums[exp_ids[i]], 64'(exp_ids[i]));
        end

        // Test 3: stall while FULL (sum 3, id 2), then drain plus refill with id 3.
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_ready%0d", i), 64'(req_ready_o), 64'd0);
            step();
            check_rsp($sformatf("t3_hold%0d", i), 64'd3, 64'd2);
        end
        rsp_ready_i = 1'b1;
        #1;
        check("t3_refill_ready", 64'(req_ready_o), 64'b1000);
        step();
        check_rsp("t3_refill", 64'd42, 64'd3);

        // Test 4: wrap-around sum drops the carry.
        req_valid_i = 4'b0000;
        step();
        check("t4_empty", 64'(rsp_valid_o), 64'd0);
        set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        req_valid_i = 4'b0001;
        #1;
        check("t4_ready", 64'(req_ready_o), 64'b0001);
        step();
        check_rsp("t4", 64'd1, 64'd0);

        // Test 5: asynchronous reset while FULL, then pointer restarts at 0.
        req_valid_i = 4'b0000;
        rsp_ready_i = 1'b0;
        #2;
        arst_i = 1'b1;
        #1;
        check("t5_async_valid", 64'(rsp_valid_o), 64'd0);
        check("t5_async_sum", rsp_sum_o, 64'd0);
        @(negedge clk_i);
        arst_i = 1'b0;
        set_op(0, 64'd10, 64'd20);
        req_valid_i = 4'b1010;
        rsp_ready_i = 1'b1;
        #1;
        check("t5_ready", 64'(req_ready_o), 64'b0010);
        step();
        check_rsp("t5_first", 64'd11, 64'd1);
        #1;
        check("t5_ready2", 64'(req_ready_o), 64'b1000);
        step();
        check_rsp("t5_second", 64'd42, 64'd3);

        // Test 6: only requester 2 valid for five cycles; pointer ends at 3.
        req_valid_i = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t6_ready%0d", i), 64'(req_ready_o), 64'b0100);
            step();
            check_rsp($sformatf("t6_rsp%0d", i), 64'd3, 64'd2);
        end
        req_valid_i = 4'b1111;
        #1;
        check("t6_ptr", 64'(req_ready_o), 64'b1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
